// File: rtl/frame_grid_sampler_pkg.sv
// grid_sampler_pkg
// Shared definitions for the frame grid sampler: controller state encoding,
// default configuration constants and a width helper.
// No ports.
package grid_sampler_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT_CNN,
        REPORT
    } state_e;

    localparam int DEF_FRAME_W  = 320;
    localparam int DEF_GRID_W   = 25;
    localparam int DEF_GRID_H   = 25;
    localparam int DEF_STRIDE_X = 12;
    localparam int DEF_STRIDE_Y = 9;
    localparam int DEF_PIX_W    = 12;
    localparam int DEF_ADDR_W   = 17;
    localparam int DEF_RD_LAT   = 1;
    localparam int DEF_PERIOD   = 100_000_000;
    localparam int DEF_CLASS_W  = 4;
    localparam int DEF_ONEHOT_W = 8;

    localparam int OVERRUN_W = 8;

    // Bits needed to hold the values 0..v-1, never less than one bit.
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/frame_grid_sampler_if.sv
// frame_grid_sampler_if
// Bundles the three neighbours of the sampler: frame-buffer read port,
// classifier start/finish, and the messenger request/ack.
//   master : the sampler (drives rd_addr, patch, patch_valid, cnn_start,
//            msg_data, msg_req)
//   slave  : the surroundings (drive rd_data, cnn_finish, cnn_class, msg_ack)
interface frame_grid_sampler_if
    import grid_sampler_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int CLASS_W  = DEF_CLASS_W,
    parameter int ONEHOT_W = DEF_ONEHOT_W
) ();

    logic [ADDR_W-1:0]              rd_addr;
    logic [PIX_W-1:0]               rd_data;
    logic [GRID_W*GRID_H*PIX_W-1:0] patch;
    logic                           patch_valid;
    logic                           cnn_start;
    logic                           cnn_finish;
    logic [CLASS_W-1:0]             cnn_class;
    logic [ONEHOT_W-1:0]            msg_data;
    logic                           msg_req;
    logic                           msg_ack;

    modport master (
        output rd_addr, patch, patch_valid, cnn_start, msg_data, msg_req,
        input  rd_data, cnn_finish, cnn_class, msg_ack
    );

    modport slave (
        input  rd_addr, patch, patch_valid, cnn_start, msg_data, msg_req,
        output rd_data, cnn_finish, cnn_class, msg_ack
    );

endinterface

// File: rtl/frame_grid_sampler_addr_gen.sv
// sample_addr_gen
// Walks the sample grid in raster order using additions only.
//   clk, rst_n : clock, async active-low reset
//   clear      : return to sample 0 (address 0)
//   step       : advance one sample; ignored on the last sample so the
//                address holds there
//   addr       : frame-buffer address of the current sample
//   idx        : flat sample index r*GRID_W+c
//   last       : current sample is the final one of the grid
module sample_addr_gen
    import grid_sampler_pkg::*;
#(
    parameter int FRAME_W  = DEF_FRAME_W,
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int STRIDE_X = DEF_STRIDE_X,
    parameter int STRIDE_Y = DEF_STRIDE_Y,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int IDX_W    = clog2_min1(GRID_W*GRID_H)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic [IDX_W-1:0]  idx,
    output logic              last
);

    localparam int COL_W = clog2_min1(GRID_W);
    localparam int ROW_W = clog2_min1(GRID_H);
    localparam logic [ADDR_W-1:0] COL_INC = ADDR_W'(STRIDE_X);
    localparam logic [ADDR_W-1:0] ROW_INC = ADDR_W'(STRIDE_Y * FRAME_W);

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              col_end;

    assign col_end = (col_q == COL_W'(GRID_W - 1));
    assign last    = col_end && (row_q == ROW_W'(GRID_H - 1));

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        addr_d     = addr_q;
        idx_d      = idx_q;
        if (clear) begin
            col_d      = '0;
            row_d      = '0;
            row_base_d = '0;
            addr_d     = '0;
            idx_d      = '0;
        end else if (step && !last) begin
            idx_d = idx_q + IDX_W'(1);
            if (col_end) begin
                // New row starts from the advanced row base, not from addr.
                col_d      = '0;
                row_d      = row_q + ROW_W'(1);
                row_base_d = row_base_q + ROW_INC;
                addr_d     = row_base_q + ROW_INC;
            end else begin
                col_d  = col_q + COL_W'(1);
                addr_d = addr_q + COL_INC;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            idx_q      <= idx_d;
        end
    end

    assign addr = addr_q;
    assign idx  = idx_q;

endmodule

// File: rtl/frame_grid_sampler.sv
// frame_grid_sampler
// Periodically samples a grid of frame-buffer pixels into a flat patch,
// starts the classifier, and reports its verdict as one-hot on a req/ack
// handshake toward the messenger.
//   clk, rst_n  : clock, async active-low reset
//   enable      : tick generation enable
//   bus         : frame-buffer / classifier / messenger signals (master side)
//   busy        : controller not idle
//   overrun_cnt : ticks dropped while busy, saturating
//
// state    | meaning
// ---------+---------------------------------------------------
// IDLE     | waiting for a tick
// FETCH    | issuing one grid address per cycle
// DRAIN    | waiting RD_LAT cycles for the last read data
// WAIT_CNN | patch valid, waiting for the classifier to finish
// REPORT   | msg_req high until msg_ack
module frame_grid_sampler
    import grid_sampler_pkg::*;
#(
    parameter int FRAME_W  = DEF_FRAME_W,
    parameter int GRID_W   = DEF_GRID_W,
    parameter int GRID_H   = DEF_GRID_H,
    parameter int STRIDE_X = DEF_STRIDE_X,
    parameter int STRIDE_Y = DEF_STRIDE_Y,
    parameter int PIX_W    = DEF_PIX_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RD_LAT   = DEF_RD_LAT,
    parameter int PERIOD   = DEF_PERIOD,
    parameter int CLASS_W  = DEF_CLASS_W,
    parameter int ONEHOT_W = DEF_ONEHOT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    frame_grid_sampler_if.master bus,
    output logic                 busy,
    output logic [OVERRUN_W-1:0] overrun_cnt
);

    localparam int N     = GRID_W * GRID_H;
    localparam int IDX_W = clog2_min1(N);
    localparam int CNT_W = clog2_min1(PERIOD);
    localparam int DR_W  = clog2_min1(RD_LAT);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     tick_cnt_q, tick_cnt_d;
    logic [OVERRUN_W-1:0] ovr_q, ovr_d;
    logic [DR_W-1:0]      drain_q, drain_d;
    logic                 patch_valid_q, patch_valid_d;
    logic                 cnn_start_q, cnn_start_d;
    logic                 msg_req_q, msg_req_d;
    logic [ONEHOT_W-1:0]  msg_data_q, msg_data_d;
    logic                 tick;

    logic                 ag_clear, ag_step, ag_last;
    logic [ADDR_W-1:0]    ag_addr;
    logic [IDX_W-1:0]     ag_idx;

    // Read-latency line: marks which cycles carry valid rd_data and for
    // which patch slot.
    logic                 line_vld_q [RD_LAT];
    logic [IDX_W-1:0]     line_idx_q [RD_LAT];
    logic [N*PIX_W-1:0]   patch_q;

    sample_addr_gen #(
        .FRAME_W  (FRAME_W),
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .STRIDE_X (STRIDE_X),
        .STRIDE_Y (STRIDE_Y),
        .ADDR_W   (ADDR_W),
        .IDX_W    (IDX_W)
    ) u_addr_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (ag_clear),
        .step  (ag_step),
        .addr  (ag_addr),
        .idx   (ag_idx),
        .last  (ag_last)
    );

    assign tick = enable && (tick_cnt_q == CNT_W'(PERIOD - 1));

    always_comb begin
        tick_cnt_d    = (!enable || tick) ? '0 : tick_cnt_q + CNT_W'(1);
        ovr_d         = ovr_q;
        state_d       = state_q;
        drain_d       = drain_q;
        patch_valid_d = patch_valid_q;
        cnn_start_d   = 1'b0;
        msg_req_d     = msg_req_q;
        msg_data_d    = msg_data_q;
        ag_clear      = 1'b0;
        ag_step       = 1'b0;

        if (tick && (state_q != IDLE) && (ovr_q != '1))
            ovr_d = ovr_q + OVERRUN_W'(1);

        case (state_q)
            IDLE: begin
                if (tick) begin
                    state_d       = FETCH;
                    patch_valid_d = 1'b0;
                    ag_clear      = 1'b1;
                end
            end
            FETCH: begin
                ag_step = 1'b1;
                if (ag_last) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (drain_q == DR_W'(RD_LAT - 1)) begin
                    state_d       = WAIT_CNN;
                    patch_valid_d = 1'b1;
                    cnn_start_d   = 1'b1;
                end else begin
                    drain_d = drain_q + DR_W'(1);
                end
            end
            WAIT_CNN: begin
                if (bus.cnn_finish) begin
                    state_d   = REPORT;
                    msg_req_d = 1'b1;
                    // Classes that do not fit the message width report as
                    // all-zero but still raise the request.
                    if (int'(bus.cnn_class) < ONEHOT_W)
                        msg_data_d = ONEHOT_W'(1) << bus.cnn_class;
                    else
                        msg_data_d = '0;
                end
            end
            REPORT: begin
                if (bus.msg_ack) begin
                    state_d   = IDLE;
                    msg_req_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            ovr_q         <= '0;
            drain_q       <= '0;
            patch_valid_q <= 1'b0;
            cnn_start_q   <= 1'b0;
            msg_req_q     <= 1'b0;
            msg_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            ovr_q         <= ovr_d;
            drain_q       <= drain_d;
            patch_valid_q <= patch_valid_d;
            cnn_start_q   <= cnn_start_d;
            msg_req_q     <= msg_req_d;
            msg_data_q    <= msg_data_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LAT; i++) begin
                line_vld_q[i] <= 1'b0;
                line_idx_q[i] <= '0;
            end
        end else begin
            line_vld_q[0] <= (state_q == FETCH);
            line_idx_q[0] <= ag_idx;
            for (int i = 1; i < RD_LAT; i++) begin
                line_vld_q[i] <= line_vld_q[i-1];
                line_idx_q[i] <= line_idx_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            patch_q <= '0;
        end else if (line_vld_q[RD_LAT-1]) begin
            patch_q[int'(line_idx_q[RD_LAT-1])*PIX_W +: PIX_W] <= bus.rd_data;
        end
    end

    assign bus.rd_addr     = ag_addr;
    assign bus.patch       = patch_q;
    assign bus.patch_valid = patch_valid_q;
    assign bus.cnn_start   = cnn_start_q;
    assign bus.msg_req     = msg_req_q;
    assign bus.msg_data    = msg_data_q;
    assign busy            = (state_q != IDLE);
    assign overrun_cnt     = ovr_q;

endmodule
